// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: widths, sequential increment, bubble word,
// the IF/ID record handed to decode, and a saturating counter helper.
package if_stage_pkg;

  localparam int unsigned XLEN  = 32'd64;
  localparam int unsigned ILEN  = 32'd32;
  localparam int unsigned CNT_W = 32'd32;

  localparam logic [XLEN-1:0] PC_INC    = 64'd4;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{pc: {XLEN{1'b0}}, instr: NOP_INSTR, valid: 1'b0};

  // Performance counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] res;
    if (cnt == {CNT_W{1'b1}}) begin
      res = cnt;
    end else begin
      res = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: redirect/hazard controls and instruction memory on one side,
// fetch address, IF/ID contents and status counters on the other.
interface if_stage_if;
  import if_stage_pkg::*;

  logic             pc_src;
  logic [XLEN-1:0]  branch_target;
  logic             stall;
  logic             flush;
  logic [ILEN-1:0]  instr_in;
  logic [XLEN-1:0]  imem_addr;
  logic [XLEN-1:0]  if_id_pc;
  logic [ILEN-1:0]  if_id_instr;
  logic             if_id_valid;
  logic             pc_misalign;
  logic [CNT_W-1:0] fetch_count;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output pc_src, branch_target, stall, flush, instr_in,
    input  imem_addr, if_id_pc, if_id_instr, if_id_valid,
           pc_misalign, fetch_count, stall_count
  );

  modport slave (
    input  pc_src, branch_target, stall, flush, instr_in,
    output imem_addr, if_id_pc, if_id_instr, if_id_valid,
           pc_misalign, fetch_count, stall_count
  );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: reset > squash > stall (hold) > load.
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   squash_i,
  input  logic   stall_i,
  input  if_id_t load_i,
  output if_id_t q_o
);

  if_id_t ifid_q;
  if_id_t ifid_d;

  always_comb begin
    ifid_d = ifid_q;
    if (squash_i) begin
      ifid_d = IF_ID_BUBBLE;
    end else if (stall_i) begin
      ifid_d = ifid_q;
    end else begin
      ifid_d = load_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_q <= IF_ID_BUBBLE;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign q_o = ifid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register with redirect/stall, IF/ID register,
// sticky misaligned-redirect flag and saturating fetch/stall counters.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_0000_0000
) (
  input  logic       clk,
  input  logic       reset,
  if_stage_if.slave  bus
);

  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  pc_d;
  logic             misalign_q;
  logic             misalign_d;
  logic [CNT_W-1:0] fetch_cnt_q;
  logic [CNT_W-1:0] fetch_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic             squash_s;
  logic             load_s;
  if_id_t           ifid_load_s;
  if_id_t           ifid_s;

  // A redirect squashes the wrong-path word fetched in the same cycle.
  assign squash_s = bus.flush | bus.pc_src;
  assign load_s   = ~squash_s & ~bus.stall;

  assign ifid_load_s = '{pc: pc_q, instr: bus.instr_in, valid: 1'b1};

  always_comb begin
    pc_d        = pc_q;
    misalign_d  = misalign_q;
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;

    if (bus.pc_src) begin
      pc_d = bus.branch_target;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_q + PC_INC;
    end

    if (bus.pc_src && (bus.branch_target[1:0] != 2'b00)) begin
      misalign_d = 1'b1;
    end else begin
      misalign_d = misalign_q;
    end

    if (load_s) begin
      fetch_cnt_d = sat_inc(fetch_cnt_q);
    end else begin
      fetch_cnt_d = fetch_cnt_q;
    end

    if (bus.stall && !bus.pc_src) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      misalign_q  <= 1'b0;
      fetch_cnt_q <= {CNT_W{1'b0}};
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      pc_q        <= pc_d;
      misalign_q  <= misalign_d;
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .squash_i (squash_s),
    .stall_i  (bus.stall),
    .load_i   (ifid_load_s),
    .q_o      (ifid_s)
  );

  assign bus.imem_addr   = pc_q;
  assign bus.if_id_pc    = ifid_s.pc;
  assign bus.if_id_instr = ifid_s.instr;
  assign bus.if_id_valid = ifid_s.valid;
  assign bus.pc_misalign = misalign_q;
  assign bus.fetch_count = fetch_cnt_q;
  assign bus.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized redirect/stall/flush
// traffic compared against a cycle-level behavioural model.
module tb_if_stage;

  logic clk = 1'b0;
  logic reset0 = 1'b1;
  logic reset1 = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  if_stage_if b0 ();
  if_stage_if b1 ();

  if_stage dut0 (.clk(clk), .reset(reset0), .bus(b0));
  if_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) dut1 (.clk(clk), .reset(reset1), .bus(b1));

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B9) ^ 32'h5A5A_0001;
  endfunction

  assign b0.instr_in = imem_word(b0.imem_addr);
  assign b1.instr_in = imem_word(b1.imem_addr);

  // model of dut0 as described by the fetch rules
  logic [63:0] m_pc = 64'd0, m_ifpc = 64'd0;
  logic [31:0] m_ifi = 32'd0, m_fc = 32'd0, m_sc = 32'd0;
  logic        m_ifv = 1'b0, m_mis = 1'b0;

  task automatic tick();
    @(posedge clk);
    if (reset0) begin
      m_pc = 64'd0; m_ifpc = 64'd0; m_ifi = 32'd0; m_ifv = 1'b0;
      m_mis = 1'b0; m_fc = 32'd0; m_sc = 32'd0;
    end else begin
      if (b0.pc_src && b0.branch_target[1:0] != 2'b00) m_mis = 1'b1;
      if (b0.stall && !b0.pc_src && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
      if (b0.flush || b0.pc_src) begin
        m_ifv = 1'b0; m_ifi = 32'd0; m_ifpc = 64'd0;
      end else if (!b0.stall) begin
        m_ifv = 1'b1; m_ifpc = m_pc; m_ifi = imem_word(m_pc);
        if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 32'd1;
      end
      if (b0.pc_src) m_pc = b0.branch_target;
      else if (!b0.stall) m_pc = m_pc + 64'd4;
    end
    #1;
  endtask

  task automatic test_reset();
    reset0 = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    reset0 = 1'b0;
    n_checks += 7;
    if (b0.imem_addr !== 64'd0)    begin n_fail++; $display("FAIL reset_imem: got %h expected 0", b0.imem_addr); end
    if (b0.if_id_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_valid: got %b expected 0", b0.if_id_valid); end
    if (b0.if_id_pc !== 64'd0)     begin n_fail++; $display("FAIL reset_ifpc: got %h expected 0", b0.if_id_pc); end
    if (b0.if_id_instr !== 32'd0)  begin n_fail++; $display("FAIL reset_instr: got %h expected 0", b0.if_id_instr); end
    if (b0.pc_misalign !== 1'b0)   begin n_fail++; $display("FAIL reset_misalign: got %b expected 0", b0.pc_misalign); end
    if (b0.fetch_count !== 32'd0)  begin n_fail++; $display("FAIL reset_fcount: got %0d expected 0", b0.fetch_count); end
    if (b0.stall_count !== 32'd0)  begin n_fail++; $display("FAIL reset_scount: got %0d expected 0", b0.stall_count); end
  endtask

  task automatic test_sequential();
    logic [63:0] a;
    for (int k = 1; k <= 2; k++) begin
      tick();
      a = 64'(4 * (k - 1));
      n_checks += 4;
      if (b0.imem_addr !== 64'(4 * k)) begin n_fail++; $display("FAIL seq_imem: got %h expected %h", b0.imem_addr, 64'(4 * k)); end
      if (b0.if_id_pc !== a)           begin n_fail++; $display("FAIL seq_ifpc: got %h expected %h", b0.if_id_pc, a); end
      if (b0.if_id_instr !== imem_word(a) || b0.if_id_valid !== 1'b1)
        begin n_fail++; $display("FAIL seq_instr: got %h/%b expected %h/1", b0.if_id_instr, b0.if_id_valid, imem_word(a)); end
      if (b0.fetch_count !== 32'(k))   begin n_fail++; $display("FAIL seq_fcount: got %0d expected %0d", b0.fetch_count, k); end
    end
  endtask

  task automatic test_stall();
    b0.stall = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      tick();
      n_checks += 4;
      if (b0.imem_addr !== 64'd8)        begin n_fail++; $display("FAIL stall_imem: got %h expected 8", b0.imem_addr); end
      if (b0.if_id_pc !== 64'd4 || b0.if_id_valid !== 1'b1)
        begin n_fail++; $display("FAIL stall_ifid: got %h/%b expected 4/1", b0.if_id_pc, b0.if_id_valid); end
      if (b0.stall_count !== 32'(k))     begin n_fail++; $display("FAIL stall_scount: got %0d expected %0d", b0.stall_count, k); end
      if (b0.fetch_count !== 32'd2)      begin n_fail++; $display("FAIL stall_fcount: got %0d expected 2", b0.fetch_count); end
    end
    b0.stall = 1'b0;
    tick();
    n_checks += 2;
    if (b0.imem_addr !== 64'd12 || b0.if_id_pc !== 64'd8)
      begin n_fail++; $display("FAIL unstall: got %h/%h expected c/8", b0.imem_addr, b0.if_id_pc); end
    if (b0.fetch_count !== 32'd3)        begin n_fail++; $display("FAIL unstall_fcount: got %0d expected 3", b0.fetch_count); end
  endtask

  task automatic test_redirect();
    b0.pc_src = 1'b1; b0.branch_target = 64'h100;
    tick();
    b0.pc_src = 1'b0;
    n_checks += 3;
    if (b0.imem_addr !== 64'h100)  begin n_fail++; $display("FAIL redir_imem: got %h expected 100", b0.imem_addr); end
    if (b0.if_id_valid !== 1'b0 || b0.if_id_instr !== 32'd0 || b0.if_id_pc !== 64'd0)
      begin n_fail++; $display("FAIL redir_bubble: got %h/%h/%b expected 0/0/0", b0.if_id_pc, b0.if_id_instr, b0.if_id_valid); end
    if (b0.fetch_count !== 32'd3)  begin n_fail++; $display("FAIL redir_fcount: got %0d expected 3", b0.fetch_count); end
    tick();
    n_checks += 2;
    if (b0.if_id_pc !== 64'h100 || b0.if_id_valid !== 1'b1 || b0.if_id_instr !== imem_word(64'h100))
      begin n_fail++; $display("FAIL redir_target: got %h/%h/%b expected 100/%h/1", b0.if_id_pc, b0.if_id_instr, b0.if_id_valid, imem_word(64'h100)); end
    if (b0.imem_addr !== 64'h104)  begin n_fail++; $display("FAIL redir_next: got %h expected 104", b0.imem_addr); end
  endtask

  task automatic test_redirect_stall();
    b0.pc_src = 1'b1; b0.stall = 1'b1; b0.branch_target = 64'h200;
    tick();
    b0.pc_src = 1'b0; b0.stall = 1'b0;
    n_checks += 3;
    if (b0.imem_addr !== 64'h200)  begin n_fail++; $display("FAIL rs_imem: got %h expected 200", b0.imem_addr); end
    if (b0.if_id_valid !== 1'b0)   begin n_fail++; $display("FAIL rs_valid: got %b expected 0", b0.if_id_valid); end
    if (b0.stall_count !== 32'd2)  begin n_fail++; $display("FAIL rs_scount: got %0d expected 2", b0.stall_count); end
    tick();
    n_checks += 1;
    if (b0.if_id_pc !== 64'h200 || b0.fetch_count !== 32'd5)
      begin n_fail++; $display("FAIL rs_after: got %h/%0d expected 200/5", b0.if_id_pc, b0.fetch_count); end
  endtask

  task automatic test_stall_flush();
    b0.stall = 1'b1; b0.flush = 1'b1;
    tick();
    b0.stall = 1'b0; b0.flush = 1'b0;
    n_checks += 2;
    if (b0.imem_addr !== 64'h204)  begin n_fail++; $display("FAIL sf_imem: got %h expected 204", b0.imem_addr); end
    if (b0.if_id_valid !== 1'b0 || b0.if_id_pc !== 64'd0 || b0.stall_count !== 32'd3)
      begin n_fail++; $display("FAIL sf_ifid: got %b/%h/%0d expected 0/0/3", b0.if_id_valid, b0.if_id_pc, b0.stall_count); end
    tick();
    n_checks += 1;
    if (b0.if_id_pc !== 64'h204 || b0.imem_addr !== 64'h208 || b0.fetch_count !== 32'd6)
      begin n_fail++; $display("FAIL sf_after: got %h/%h/%0d expected 204/208/6", b0.if_id_pc, b0.imem_addr, b0.fetch_count); end
  endtask

  task automatic test_misalign();
    b0.pc_src = 1'b1; b0.branch_target = 64'h102;
    tick();
    b0.pc_src = 1'b0;
    n_checks += 1;
    if (b0.imem_addr !== 64'h102 || b0.pc_misalign !== 1'b1)
      begin n_fail++; $display("FAIL mis_set: got %h/%b expected 102/1", b0.imem_addr, b0.pc_misalign); end
    for (int k = 1; k <= 2; k++) begin
      tick();
      n_checks += 1;
      if (b0.pc_misalign !== 1'b1 || b0.imem_addr !== 64'h102 + 64'(4 * k))
        begin n_fail++; $display("FAIL mis_sticky: got %b/%h expected 1/%h", b0.pc_misalign, b0.imem_addr, 64'h102 + 64'(4 * k)); end
    end
    reset0 = 1'b1;
    tick();
    reset0 = 1'b0;
    n_checks += 1;
    if (b0.pc_misalign !== 1'b0 || b0.imem_addr !== 64'd0 || b0.fetch_count !== 32'd0)
      begin n_fail++; $display("FAIL mis_clear: got %b/%h/%0d expected 0/0/0", b0.pc_misalign, b0.imem_addr, b0.fetch_count); end
  endtask

  task automatic test_random();
    logic [63:0] tgt;
    for (int c = 0; c < 400; c++) begin
      reset0 = ($urandom_range(63) == 0);
      b0.pc_src = ($urandom_range(7) == 0);
      b0.stall  = ($urandom_range(3) == 0);
      b0.flush  = ($urandom_range(7) == 0);
      tgt = {$urandom, $urandom};
      if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
      b0.branch_target = tgt;
      tick();
      n_checks += 1;
      if ({b0.imem_addr, b0.if_id_pc, b0.if_id_instr, b0.if_id_valid, b0.pc_misalign, b0.fetch_count, b0.stall_count}
          !== {m_pc, m_ifpc, m_ifi, m_ifv, m_mis, m_fc, m_sc})
        begin
          n_fail++;
          $display("FAIL rand_cycle%0d: got pc=%h ifpc=%h ins=%h v=%b mis=%b fc=%0d sc=%0d expected pc=%h ifpc=%h ins=%h v=%b mis=%b fc=%0d sc=%0d",
                   c, b0.imem_addr, b0.if_id_pc, b0.if_id_instr, b0.if_id_valid, b0.pc_misalign, b0.fetch_count, b0.stall_count,
                   m_pc, m_ifpc, m_ifi, m_ifv, m_mis, m_fc, m_sc);
        end
    end
    reset0 = 1'b0; b0.pc_src = 1'b0; b0.stall = 1'b0; b0.flush = 1'b0;
  endtask

  task automatic test_wrap();
    logic [63:0] exp_pc [3];
    exp_pc[0] = 64'hFFFF_FFFF_FFFF_FFFC; exp_pc[1] = 64'd0; exp_pc[2] = 64'd4;
    reset1 = 1'b1;
    tick(); tick();
    reset1 = 1'b0;
    n_checks += 1;
    if (b1.imem_addr !== 64'hFFFF_FFFF_FFFF_FFF8) begin n_fail++; $display("FAIL wrap_reset: got %h expected fffffffffffffff8", b1.imem_addr); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks += 1;
      if (b1.imem_addr !== exp_pc[k]) begin n_fail++; $display("FAIL wrap_pc%0d: got %h expected %h", k, b1.imem_addr, exp_pc[k]); end
    end
    n_checks += 1;
    if (b1.if_id_pc !== 64'd0 || b1.fetch_count !== 32'd3)
      begin n_fail++; $display("FAIL wrap_ifid: got %h/%0d expected 0/3", b1.if_id_pc, b1.fetch_count); end
    reset1 = 1'b1;
    tick();
    n_checks += 1;
    if (b1.imem_addr !== 64'hFFFF_FFFF_FFFF_FFF8 || b1.if_id_valid !== 1'b0 || b1.if_id_pc !== 64'd0 ||
        b1.if_id_instr !== 32'd0 || b1.fetch_count !== 32'd0 || b1.stall_count !== 32'd0 || b1.pc_misalign !== 1'b0)
      begin n_fail++; $display("FAIL wrap_midreset: got pc=%h v=%b ifpc=%h fc=%0d expected fffffffffffffff8/0/0/0",
                                b1.imem_addr, b1.if_id_valid, b1.if_id_pc, b1.fetch_count); end
  endtask

  initial begin
    b0.pc_src = 1'b0; b0.stall = 1'b0; b0.flush = 1'b0; b0.branch_target = 64'd0;
    b1.pc_src = 1'b0; b1.stall = 1'b0; b1.flush = 1'b0; b1.branch_target = 64'd0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_stall_flush();
    test_misalign();
    test_random();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
